// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received word and per-frame flags from uart_rx to the command decoder
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    modport master (output rx_data, rx_valid, parity_err, frame_err, busy);
    modport slave  (input  rx_data, rx_valid, parity_err, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with parity/framing checks
module uart_rx #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD_RATE   = 115200,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx_lane,
    output logic      rx_probe,
    uart_rx_if.master rx
);
    localparam int TICK_DIV = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
    localparam int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW       = $clog2(OVERSAMPLE);
    localparam int BW       = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [2:0]           sync = 3'b111;
    logic                 rx_s;
    logic [CW-1:0]        cnt;
    logic                 tick;
    logic [SW-1:0]        s;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr_q;
    logic                 samp;
    logic                 s_clr;
    logic                 bit_clr;
    logic                 shift_en;
    logic                 par_ld;
    logic                 emit_valid;
    logic                 emit_ferr;

    always_ff @(posedge clk) begin
        if (rst) sync <= 3'b111;
        else     sync <= {sync[1:0], rx_lane};
    end

    assign rx_s     = sync[2];
    assign rx_probe = rx_s;

    // Tick counter sits at zero while the lane idles so the first tick lands a fixed distance from the start edge.
    assign tick = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || (state == S_IDLE && rx_s) || tick) cnt <= '0;
        else                                         cnt <= cnt + CW'(1);
    end

    assign samp = tick && (s == SW'(OVERSAMPLE - 1));

    always_ff @(posedge clk) begin
        if (rst || state == S_IDLE || s_clr) s <= '0;
        else if (tick)                       s <= (s == SW'(OVERSAMPLE - 1)) ? '0 : s + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n    = state;
        s_clr      = 1'b0;
        bit_clr    = 1'b0;
        shift_en   = 1'b0;
        par_ld     = 1'b0;
        emit_valid = 1'b0;
        emit_ferr  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s) state_n = S_START;
            end
            S_START: begin
                if (tick && s == SW'(OVERSAMPLE / 2 - 1)) begin
                    s_clr   = 1'b1;
                    bit_clr = 1'b1;
                    state_n = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (samp) begin
                    shift_en = 1'b1;
                    if (bit_idx == BW'(DATA_BITS - 1))
                        state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (samp) begin
                    par_ld  = 1'b1;
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (samp) begin
                    if (rx_s) begin
                        emit_valid = 1'b1;
                        state_n    = S_IDLE;
                    end else begin
                        emit_ferr = 1'b1;
                        state_n   = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (rx_s) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx <= '0;
            shreg   <= '0;
            perr_q  <= 1'b0;
        end else begin
            if (bit_clr)       bit_idx <= '0;
            else if (shift_en) bit_idx <= bit_idx + BW'(1);
            if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            // Odd mode expects the XOR of data and parity bit to be 1, even mode 0.
            if (bit_clr)     perr_q <= 1'b0;
            else if (par_ld) perr_q <= (^{shreg, rx_s}) ^ (PARITY == 2);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx.rx_data    <= '0;
            rx.rx_valid   <= 1'b0;
            rx.parity_err <= 1'b0;
            rx.frame_err  <= 1'b0;
        end else begin
            rx.rx_valid   <= emit_valid;
            rx.parity_err <= emit_valid && perr_q && (PARITY != 0);
            rx.frame_err  <= emit_ferr;
            if (emit_valid) rx.rx_data <= shreg;
        end
    end

    assign rx.busy = (state != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx (8N1 and 7E1 instances)
module tb_uart_rx;
    localparam int BIT = 864;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        int         lat_start;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic lane_a;
    logic lane_b;
    logic probe_a;
    logic probe_b;

    uart_rx_if #(.DATA_BITS(8)) ifa ();
    uart_rx_if #(.DATA_BITS(7)) ifb ();

    uart_rx dut_a (
        .clk      (clk),
        .rst      (rst),
        .rx_lane  (lane_a),
        .rx_probe (probe_a),
        .rx       (ifa)
    );

    uart_rx #(.DATA_BITS(7), .PARITY(1)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .rx_lane  (lane_b),
        .rx_probe (probe_b),
        .rx       (ifb)
    );

    exp_t       qa[$];
    exp_t       qb[$];
    exp_t       ea;
    exp_t       eb;
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [8:0] last_a = '0;
    logic [8:0] last_b = '0;
    logic       prev_a = 1'b0;
    logic       prev_b = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_lat(input int lat);
        n_cmp++;
        if (lat < 8210 || lat > 8214) begin
            n_err++;
            $display("FAIL latency: got %0d clocks expected 8210..8214", lat);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (ifa.rx_valid || ifa.frame_err)) begin
            if (qa.size() == 0) begin
                check("a_unexpected_event", {ifa.rx_valid, ifa.frame_err}, 0);
            end else begin
                ea = qa.pop_front();
                check("a_valid", ifa.rx_valid, !ea.ferr);
                check("a_data", {1'b0, ifa.rx_data}, ea.data);
                check("a_perr", ifa.parity_err, ea.perr);
                check("a_ferr", ifa.frame_err, ea.ferr);
                if (ea.lat_start >= 0) check_lat(cyc - ea.lat_start);
            end
        end
        if (!rst && prev_a) check("a_pulse_width", {ifa.rx_valid, ifa.frame_err}, 0);
        prev_a = !rst && (ifa.rx_valid || ifa.frame_err);
    end

    always @(negedge clk) begin
        if (!rst && (ifb.rx_valid || ifb.frame_err)) begin
            if (qb.size() == 0) begin
                check("b_unexpected_event", {ifb.rx_valid, ifb.frame_err}, 0);
            end else begin
                eb = qb.pop_front();
                check("b_valid", ifb.rx_valid, !eb.ferr);
                check("b_data", {2'b0, ifb.rx_data}, eb.data);
                check("b_perr", ifb.parity_err, eb.perr);
                check("b_ferr", ifb.frame_err, eb.ferr);
            end
        end
        if (!rst && prev_b) check("b_pulse_width", {ifb.rx_valid, ifb.frame_err, ifb.parity_err}, 0);
        prev_b = !rst && (ifb.rx_valid || ifb.frame_err);
    end

    task automatic set_lane(input int which, input logic v);
        if (which == 0) lane_a = v;
        else            lane_b = v;
    endtask

    task automatic wait_bit();
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    // which: 0 = 8N1 instance, 1 = 7E1 instance
    task automatic send(input int which, input logic [8:0] d, input int nb, input bit has_p,
                        input logic p, input logic stop, input logic exp_perr,
                        input bit expect_out, input bit lat);
        exp_t e;
        @(posedge clk);
        #1;
        e.data      = stop ? d : (which == 0 ? last_a : last_b);
        e.perr      = exp_perr;
        e.ferr      = !stop;
        e.lat_start = lat ? cyc : -1;
        if (expect_out) begin
            if (which == 0) qa.push_back(e);
            else            qb.push_back(e);
            if (stop && which == 0) last_a = d;
            if (stop && which == 1) last_b = d;
        end
        set_lane(which, 1'b0);
        wait_bit();
        for (int i = 0; i < nb; i++) begin
            set_lane(which, d[i]);
            wait_bit();
        end
        if (has_p) begin
            set_lane(which, p);
            wait_bit();
        end
        set_lane(which, stop);
        wait_bit();
    endtask

    initial begin
        rst    = 1'b1;
        lane_a = 1'b1;
        lane_b = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid", ifa.rx_valid, 0);
        check("rst_busy", ifa.busy, 0);
        check("rst_data", ifa.rx_data, 0);
        check("rst_perr", ifa.parity_err, 0);
        check("rst_ferr", ifa.frame_err, 0);
        check("rst_probe", probe_a, 1);
        check("rst_busy_b", ifb.busy, 0);
        repeat (20) @(posedge clk);

        // NULL byte with latency measured from the falling edge
        send(0, 9'h000, 8, 0, 1'b0, 1'b1, 1'b0, 1, 1);
        repeat (50) @(posedge clk);

        send(0, 9'h055, 8, 0, 1'b0, 1'b1, 1'b0, 1, 0);
        send(0, 9'h0A3, 8, 0, 1'b0, 1'b1, 1'b0, 1, 0);
        repeat (50) @(posedge clk);
        #1;
        check("busy_after_pair", ifa.busy, 0);

        // false start: 300 low clocks is shorter than half a bit
        lane_a = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        lane_a = 1'b1;
        repeat (1000) @(posedge clk);
        #1;
        check("glitch_busy", ifa.busy, 0);

        // stop bit low, then a break held for 2000 clocks
        send(0, 9'h03C, 8, 0, 1'b0, 1'b0, 1'b0, 1, 0);
        repeat (2000) @(posedge clk);
        #1;
        check("wait_idle_busy", ifa.busy, 1);
        lane_a = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("released_busy", ifa.busy, 0);
        send(0, 9'h07E, 8, 0, 1'b0, 1'b1, 1'b0, 1, 0);
        repeat (50) @(posedge clk);

        // 7E1: 0x41 two ones, 0x43 three ones, 0x7F seven ones
        send(1, 9'h041, 7, 1, 1'b0, 1'b1, 1'b0, 1, 0);
        send(1, 9'h041, 7, 1, 1'b1, 1'b1, 1'b1, 1, 0);
        send(1, 9'h043, 7, 1, 1'b1, 1'b1, 1'b0, 1, 0);
        send(1, 9'h07F, 7, 1, 1'b0, 1'b1, 1'b1, 1, 0);
        repeat (50) @(posedge clk);

        // reset pulse during data bit 4 of 0xFF
        fork
            send(0, 9'h0FF, 8, 0, 1'b0, 1'b1, 1'b0, 0, 0);
            begin
                repeat (BIT * 5 + 400) @(posedge clk);
                #1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst    = 1'b0;
                last_a = '0;
                last_b = '0;
                check("midrst_busy", ifa.busy, 0);
                check("midrst_data", ifa.rx_data, 0);
                check("midrst_probe", probe_a, 1);
            end
        join
        repeat (50) @(posedge clk);
        send(0, 9'h012, 8, 0, 1'b0, 1'b1, 1'b0, 1, 0);
        repeat (100) @(posedge clk);
        #1;
        check("a_leftover", qa.size(), 0);
        check("b_leftover", qb.size(), 0);
        check("final_data", ifa.rx_data, 8'h12);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Full UART receiver that replaces the dummy start-detector.
- Re-synchronises the serial lane into the 100 MHz domain.
- Oversamples each bit and de-serialises a parametrised frame (data bits, optional parity, one stop bit).
- Presents each received word with a single-cycle valid strobe and per-frame error flags, for the command decoder in the top level.

Parameters:
CLK_FREQ_HZ, 100000000, system clock frequency in Hz
BAUD_RATE, 115200, serial bit rate
OVERSAMPLE, 16, sample ticks per bit period; must be even and >= 4
DATA_BITS, 8, payload bits per frame, legal range 5..9
PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd

Ports:
clk  input  1  on-board system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
rx_lane  input  1  asynchronous serial input; idles high
rx_data  output  DATA_BITS  last received payload, LSB = first bit on the line
rx_valid  output  1  one-clock pulse: rx_data updated with a correctly framed word
parity_err  output  1  one-clock pulse coincident with rx_valid when parity mismatches; 0 when PARITY = 0
frame_err  output  1  one-clock pulse when the stop bit samples low
busy  output  1  high from start-bit detection until return to IDLE
rx_probe  output  1  synchronised lane, for oscilloscope debug

Behaviour:
- Synchroniser
  - 3 flops; power-up value and reset value 1.
  - rx_s = third flop, so the lane reaches the FSM 3 clocks after rx_lane.
- Tick generator
  - TICK_DIV = CLK_FREQ_HZ / (BAUD_RATE*OVERSAMPLE), integer floor; default 54.
  - Counter 0..TICK_DIV-1; a tick pulse fires when it wraps.
  - Counter is held cleared in IDLE and starts counting on the start-bit detection cycle.
- Sample counter s: 0..OVERSAMPLE-1, advances on each tick.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE. Reset state is IDLE.
- IDLE: when rx_s == 0, go to START and clear s. busy rises on the next clock.
- START: on the tick where s == OVERSAMPLE/2-1 (bit middle):
  - rx_s == 0: go to DATA and clear s and the bit index.
  - rx_s == 1: glitch / false start; go back to IDLE. No flags are raised.
- DATA: on each tick where s == OVERSAMPLE-1 (one full bit after the previous midpoint):
  - Shift rx_s into bit [DATA_BITS-1] of the shift register, shifting right.
  - Increment the bit index.
  - After DATA_BITS samples, go to PARITY if PARITY != 0, else to STOP.
- PARITY: sample the same way.
  - Even: error if XOR(data, p) != 0.
  - Odd: error if XOR(data, p) != 1.
  - The result is latched; then go to STOP.
- STOP: sample the same way.
  - rx_s == 1: on the next clock, rx_data <= shift register, rx_valid = 1 and parity_err = latched value for that single cycle; go to IDLE.
  - rx_s == 0: frame_err = 1 for one clock, rx_valid stays 0, rx_data is unchanged; go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s == 1, then go to IDLE. Handles break conditions and bytes that are held low.
- busy is low only in IDLE.
- Output holding: rx_data holds its value between frames. rx_valid, parity_err and frame_err are never high for more than one clock.
- Back-to-back frames: a start edge seen in IDLE the cycle after STOP completes must be captured; no dead time beyond one clock.
- Reset mid-frame: all state returns to IDLE and the synchroniser flops go to 1. Outputs on reset: rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, busy = 0. No partial word is ever emitted.
- Simultaneous rst with a stop-sample event: rst wins.

Test Plan:
1. Defaults (8N1, 115200, bit = 864 clocks); send 0x55 then immediately 0xA3 → two rx_valid pulses, rx_data = 0x55 then 0xA3, no error flags, busy low between frames for <= 2 clocks.
2. Send 0x00 (NULL) → rx_valid with rx_data = 0x00. Confirm rx_valid fires about 864*9.5 + 4 clocks after the falling edge, within ±2 clocks.
3. Drive rx_lane low for 300 clocks, then high → no rx_valid, no frame_err, busy drops, FSM is back in IDLE.
4. Send 0x3C with stop bit forced low, then hold low for 2000 clocks, then release and send 0x7E → frame_err pulse once with rx_valid = 0 and rx_data still the previous value; stays in WAIT_IDLE until release; then 0x7E is received cleanly.
5. PARITY = 1, DATA_BITS = 7: send 0x41 with correct parity bit 0 → rx_valid with parity_err = 0; repeat with parity bit 1 → rx_valid with parity_err = 1 in the same cycle.
6. Assert rst for 1 clock during data bit 4 of 0xFF → busy = 0 and no rx_valid; the following 0x12 frame is received correctly.
